alert_handler_lpg_init_seq: RTL
===============================

Name: alert_handler_lpg_init_seq

Overview:
Sequences re-initialization of alert channels when a low-power group (LPG) leaves clock-gated or reset state. Per-LPG wake events are captured as pending requests. A round-robin arbiter grants one LPG at a time to the shared init resource via a req/ack handshake, with a settle period and a timeout. The block sits between the synchronized per-LPG low-power indications and the alert channel init logic in the alert handler.

Parameters:
NLpg, 4, number of low-power groups (>=2)
SettleCycles, 4, cycles spent in Settle after each init (>=1)
TimeoutCycles, 64, cycles in Req without ack before timeout (>=2)
NLpgW, $clog2(NLpg), index width (derived, not overridable)

Ports:
clk_i  input  1  clock
rst_i  input  1  synchronous reset, active-high
enable_i  input  1  1 = new grants allowed; in-flight op always completes
lpg_active_i  input  NLpg  1 = LPG k currently gated/in reset (already synced, decoded)
init_ack_i  input  1  init resource done with current LPG
init_req_o  output  1  init request to shared resource
init_lpg_idx_o  output  NLpgW  LPG being serviced; valid while init_req_o or timeout_o
pending_o  output  NLpg  pending wake requests
busy_o  output  1  FSM not in Idle
timeout_o  output  1  one-cycle pulse on Req timeout
timeout_err_o  output  1  sticky; set on any timeout, cleared only by reset

Behaviour:
- Reset (rst_i sampled high at a clock edge): state=Idle, pending='0, lpg_active_q='1 (all groups treated as asleep), rr_ptr=0, idx=0, timers=0, timeout_err_o=0. Resulting outputs: init_req_o=0, busy_o=0, timeout_o=0. Reset mid-operation aborts immediately; there is no ack wait.
- Edge detect: lpg_active_q <= lpg_active_i every cycle.
  - fall[k] = q[k] & ~i[k] (wake).
  - rise[k] = ~q[k] & i[k] (sleep).
- Pending update, per k:
  - fall[k] sets pending[k].
  - Otherwise rise[k] clears it.
  - Otherwise a grant of k clears it.
  - Set has priority over both clears.
- Because lpg_active_q resets to all 1, every LPG that is awake after reset produces a wake event.
- Arbiter: in Idle with enable_i=1 and pending!=0, grant the first set bit searching rr_ptr, rr_ptr+1, ... with wrap at NLpg.
  - On grant: idx <= granted, rr_ptr <= (granted+1) mod NLpg, pending[granted] cleared.
- FSM states: Idle, Req, Settle.
  - init_req_o = (state==Req). busy_o = (state!=Idle).
  - Idle -> Req on grant. Otherwise stay.
  - Req: timer counts from 0 each cycle.
    - init_ack_i=1 -> Settle, settle counter loaded with SettleCycles-1.
    - Else if lpg_active_i[idx]=1 (group went back to sleep) -> Idle (abort). No timeout, no re-queue.
    - Else if timer==TimeoutCycles-1 -> timeout_o=1 that cycle, timeout_err_o<=1, -> Settle.
    - Priority: ack > abort > timeout.
  - Settle: counter decrements. At 0 -> Idle. Settle lasts exactly SettleCycles cycles.
  - init_ack_i outside Req is ignored.
- Latency: with enable_i=1 and FSM Idle, a fall seen at edge t gives pending at t+1, grant at edge t+1, and init_req_o=1 from cycle t+2.
- Back-to-back: minimum gap between two grants is 1 (Req) + SettleCycles + 1 (Idle) cycles.
- A wake event on the LPG currently in Req/Settle sets its pending bit, so it is serviced again later.
- enable_i=0: pending bits keep accumulating; no grants are made.
- Counter widths cover TimeoutCycles and SettleCycles without wrap.

Test Plan:
- Reset, then lpg_active_i=4'b0000 -> pending=4'b1111 at cycle 1. Grants in order 0,1,2,3. Ack each 3 cycles after req. init_req_o rises 1+3+4+1 = 9 cycles apart.
- lpg_active_i=1111 steady, then LPG2 falls at t -> init_req_o=1, idx=2 at t+2. Ack at t+5 -> busy_o=0 at t+10.
- Never ack LPG1 -> timeout_o pulses at 64th Req cycle, timeout_err_o=1 sticky. After Settle the next pending LPG is granted.
- LPG3 in Req, lpg_active_i[3] rises before ack -> init_req_o drops next cycle, no timeout, pending[3]=0.
- enable_i=0, LPGs 1 and 3 wake -> no req, pending=1010. Set enable_i=1 with rr_ptr=2 -> LPG3 granted first, then LPG1.
- rst_i asserted mid-Req -> next cycle init_req_o=0, pending=0, timeout_err_o=0.

Source files
------------

// File: rtl/alert_handler_lpg_init_seq.sv
// Low-power-group init sequencer: captures per-LPG wake events as pending requests and
// hands them one at a time, round-robin, to the shared alert-channel init resource.
module alert_handler_lpg_init_seq #(
  parameter int NLpg          = 4,
  parameter int SettleCycles  = 4,
  parameter int TimeoutCycles = 64,
  localparam int NLpgW        = (NLpg > 1) ? $clog2(NLpg) : 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             enable_i,
  input  logic [NLpg-1:0]  lpg_active_i,
  input  logic             init_ack_i,
  output logic             init_req_o,
  output logic [NLpgW-1:0] init_lpg_idx_o,
  output logic [NLpg-1:0]  pending_o,
  output logic             busy_o,
  output logic             timeout_o,
  output logic             timeout_err_o
);

  // state  | meaning
  // Idle   | waiting for a pending LPG and enable
  // Req    | init_req_o high, waiting for ack / abort / timeout
  // Settle | fixed quiet period after each init before the next grant

  localparam int TmrW = $clog2(TimeoutCycles);
  localparam int SetW = $clog2(SettleCycles + 1);

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StReq    = 2'd1,
    StSettle = 2'd2
  } state_e;

  state_e            state, state_next;
  logic [NLpg-1:0]   active_q;
  logic [NLpg-1:0]   pending, pending_next;
  logic [NLpg-1:0]   fall, rise;
  logic [NLpgW-1:0]  idx, idx_next;
  logic [NLpgW-1:0]  rr_ptr, rr_ptr_next;
  logic [NLpgW-1:0]  grant_idx, grant_ptr, cand_idx;
  logic              grant_found, grant;
  logic [TmrW-1:0]   timer, timer_next;
  logic [SetW-1:0]   settle_cnt, settle_next;
  logic              timeout;
  logic              err;
  int                cand;

  assign fall = active_q & ~lpg_active_i;
  assign rise = ~active_q & lpg_active_i;

  // Round-robin search starting at rr_ptr, wrapping at NLpg.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    grant_ptr   = '0;
    cand        = 0;
    cand_idx    = '0;
    for (int i = 0; i < NLpg; i++) begin
      cand     = (int'(rr_ptr) + i) % NLpg;
      cand_idx = NLpgW'(cand);
      if (!grant_found && pending[cand_idx]) begin
        grant_found = 1'b1;
        grant_idx   = cand_idx;
        grant_ptr   = NLpgW'((cand + 1) % NLpg);
      end
    end
  end

  always_comb begin
    state_next  = state;
    idx_next    = idx;
    rr_ptr_next = rr_ptr;
    timer_next  = timer;
    settle_next = settle_cnt;
    timeout     = 1'b0;
    grant       = 1'b0;
    unique case (state)
      StIdle: begin
        if (enable_i && grant_found) begin
          grant       = 1'b1;
          idx_next    = grant_idx;
          rr_ptr_next = grant_ptr;
          timer_next  = '0;
          state_next  = StReq;
        end
      end
      StReq: begin
        if (init_ack_i) begin
          settle_next = SetW'(SettleCycles - 1);
          state_next  = StSettle;
        end else if (lpg_active_i[idx]) begin
          // group fell back asleep: drop the request without re-queueing it
          state_next = StIdle;
        end else if (timer == TmrW'(TimeoutCycles - 1)) begin
          timeout     = 1'b1;
          settle_next = SetW'(SettleCycles - 1);
          state_next  = StSettle;
        end else begin
          timer_next = timer + TmrW'(1);
        end
      end
      StSettle: begin
        if (settle_cnt == '0) begin
          state_next = StIdle;
        end else begin
          settle_next = settle_cnt - SetW'(1);
        end
      end
      default: state_next = StIdle;
    endcase
  end

  // A new wake event wins over both sleep and grant clears.
  always_comb begin
    pending_next = pending;
    for (int k = 0; k < NLpg; k++) begin
      pending_next[k] = fall[k] |
                        (pending[k] & ~rise[k] & ~(grant && (grant_idx == NLpgW'(k))));
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state      <= StIdle;
      active_q   <= '1;
      pending    <= '0;
      rr_ptr     <= '0;
      idx        <= '0;
      timer      <= '0;
      settle_cnt <= '0;
      err        <= 1'b0;
    end else begin
      state      <= state_next;
      active_q   <= lpg_active_i;
      pending    <= pending_next;
      rr_ptr     <= rr_ptr_next;
      idx        <= idx_next;
      timer      <= timer_next;
      settle_cnt <= settle_next;
      err        <= err | timeout;
    end
  end

  assign init_req_o     = (state == StReq);
  assign busy_o         = (state != StIdle);
  assign init_lpg_idx_o = idx;
  assign pending_o      = pending;
  assign timeout_o      = timeout;
  assign timeout_err_o  = err;

  grant_is_pending_a: assert property (@(posedge clk_i) disable iff (rst_i)
    grant |-> pending[grant_idx]);
  timeout_only_in_req_a: assert property (@(posedge clk_i) disable iff (rst_i)
    timeout_o |-> init_req_o);

endmodule
